router_pkt_sink: RTL and testbench
==================================

ROUTER_PKT_SINK -- requirements
Module: router_pkt_sink

Interface
REQ-001 SHALL have parameter READ_DELAY, default 2: cycles from valid_out seen high in IDLE to first read_enb; legal 0..20.
REQ-002 SHALL have port: clock  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: sink_en  input  1  when low, no new packet is started.
REQ-005 SHALL have port: valid_out  input  1  router output-port FIFO not empty.
REQ-006 SHALL have port: data_out  input  8  router port data, valid the cycle after read_enb.
REQ-007 SHALL have port: read_enb  output  1  FIFO read strobe to router.
REQ-008 SHALL have port: byte_data  output  8  payload byte.
REQ-009 SHALL have port: byte_vld  output  1  byte_data holds a payload byte this cycle.
REQ-010 SHALL have port: pkt_done  output  1  one-cycle pulse at end of every packet, good or bad.
REQ-011 SHALL have port: pkt_len  output  6  header length of last completed packet.
REQ-012 SHALL have port: pkt_addr  output  2  header address of last completed packet.
REQ-013 SHALL have port: parity_err  output  1  pulse with pkt_done when XOR of all bytes is nonzero.
REQ-014 SHALL have port: len_err  output  1  pulse with pkt_done when header length is 0.
REQ-015 SHALL have port: trunc_err  output  1  pulse with pkt_done when valid_out falls before all bytes are read.
REQ-016 SHALL have port: pkt_count  output  16  completed packets, saturating.
REQ-017 SHALL have port: err_count  output  8  packets with any error, saturating.

Function
REQ-018 SHALL implement states IDLE, WAIT, HDR, BODY, DONE.
REQ-019 IDLE -> WAIT when valid_out=1 and sink_en=1; delay counter cleared.
REQ-020 WAIT SHALL hold READ_DELAY cycles, then go to HDR; READ_DELAY=0 goes to HDR the next cycle.
REQ-021 read_enb SHALL be registered, high in HDR and BODY only while reads issued < required reads.
REQ-022 Required reads SHALL be 2 until the header is captured, then header[7:2]+2 (header, payload, parity).
REQ-023 HDR: first captured byte is the header; pkt_len<=header[7:2], pkt_addr<=header[1:0]; go to BODY.
REQ-024 Header length 0 SHALL consume header plus one parity byte and flag len_err.
REQ-025 BODY: each captured byte except the last SHALL appear on byte_data with byte_vld=1 that cycle; the last byte is parity and is not forwarded.
REQ-026 Running parity SHALL be the XOR of all captured bytes including parity; nonzero at end flags parity_err.
REQ-027 DONE SHALL last one cycle: pkt_done=1, error pulses valid, counters update, then IDLE.
REQ-028 valid_out=0 in HDR/BODY while a read is outstanding SHALL drop read_enb next cycle, flag trunc_err, and go to DONE.
REQ-029 sink_en low in WAIT/HDR/BODY SHALL not interrupt the current packet.
REQ-030 A packet queued behind the current one SHALL start from IDLE the cycle after DONE; worst-case gap from valid_out to first read is READ_DELAY+2 cycles, under the router's 30-cycle soft-reset timeout.
REQ-031 pkt_count and err_count SHALL hold at all-ones without wrap.

Reset
REQ-032 reset SHALL immediately force IDLE, read_enb=0, byte_vld=0, pkt_done=0, all error pulses 0, pkt_len=0, pkt_addr=0, byte_data=0, counters 0, parity accumulator 0.
REQ-033 Reset asserted mid-packet SHALL discard the packet with no pkt_done.

Structure
REQ-034 State encoding, header field positions (LEN=[7:2], ADDR=[1:0]), and the 30-cycle timeout constant SHALL live in the shared router package.
REQ-035 The block SHALL be one module; the saturating counter SHALL be a sub-module, sat_counter, parameterised by width and instantiated twice.

Verification
REQ-036 Header 0x22 (len 8, addr 2), 8 random bytes, correct parity -> 8 byte_vld pulses, pkt_done, pkt_len=8, pkt_addr=2, no errors, pkt_count=1.
REQ-037 Header 0x16 (len 5), parity byte XOR 0x01 -> pkt_done with parity_err=1, err_count=1.
REQ-038 Two back-to-back len-5 packets in FIFO -> two pkt_done pulses; second read_enb rise at most READ_DELAY+2 cycles after first DONE.
REQ-039 sink_en=0 for 10 cycles with valid_out=1 -> read_enb stays 0; sink_en=1 -> read_enb high after READ_DELAY+1 cycles, packet received intact.
REQ-040 valid_out forced 0 after 3 payload bytes of a len-8 packet -> trunc_err=1, pkt_done=1, return to IDLE.
REQ-041 reset pulsed after 4th payload byte -> all outputs at reset values; a following len-8 packet completes cleanly with pkt_count=1.

Source files
------------

// File: rtl/router_pkt_sink_pkg.sv
// Shared router definitions for the packet sink.
// Contents: sink FSM state encoding, header field positions (LEN / ADDR),
// the router soft-reset timeout, and small header decode helpers.
package router_pkt_sink_pkg;

    // Sink FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_HDR  = 3'd2,
        ST_BODY = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Header byte layout: [7:2] payload length, [1:0] destination address
    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    // Router drops a port's packet if it is not read within this many cycles
    localparam int SOFT_RST_TIMEOUT = 30;

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

    // Total FIFO reads for a packet: header + payload + parity
    function automatic logic [6:0] reads_for_hdr(input logic [7:0] hdr);
        return {1'b0, hdr_len(hdr)} + 7'd2;
    endfunction

endpackage

// File: rtl/router_pkt_sink_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
// Ports: clock_i, reset_i (async, active-high), inc_i, count_o[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [WIDTH-1:0] MAX_C = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: step unless already saturated
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != MAX_C)) begin
            count_d = count_q + ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/router_pkt_sink.sv
// Router output-port packet sink. Waits READ_DELAY cycles after the port
// FIFO reports data, then reads one packet (header, payload, parity),
// forwards payload bytes, and reports completion plus error status.
// Ports:
//   clock, reset (async, active-high)
//   sink_en            - gate for starting a new packet
//   valid_out/data_out - router FIFO not-empty / data (one cycle after read)
//   read_enb           - registered FIFO read strobe
//   byte_data/byte_vld - forwarded payload byte
//   pkt_done + parity_err/len_err/trunc_err - end-of-packet pulses
//   pkt_len/pkt_addr   - header fields of the last packet
//   pkt_count/err_count - saturating packet / errored-packet counters
module router_pkt_sink
    import router_pkt_sink_pkg::*;
#(
    parameter int READ_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sink_en,
    input  logic        valid_out,
    input  logic [7:0]  data_out,
    output logic        read_enb,
    output logic [7:0]  byte_data,
    output logic        byte_vld,
    output logic        pkt_done,
    output logic [5:0]  pkt_len,
    output logic [1:0]  pkt_addr,
    output logic        parity_err,
    output logic        len_err,
    output logic        trunc_err,
    output logic [15:0] pkt_count,
    output logic [7:0]  err_count
);

    // Keep first-read latency (delay + IDLE + WAIT entry) under the router timeout
    localparam int EFF_DELAY = (READ_DELAY + 2 < SOFT_RST_TIMEOUT) ? READ_DELAY
                                                                   : SOFT_RST_TIMEOUT - 3;
    localparam logic [4:0] RD_C = 5'(EFF_DELAY);

    state_e      state_q, state_d;
    logic [4:0]  dly_q, dly_d;
    logic [6:0]  issued_q, issued_d;     // reads strobed so far
    logic [6:0]  req_q, req_d;           // reads this packet needs
    logic [6:0]  cap_q, cap_d;           // bytes captured so far
    logic        rd_pend_q, rd_pend_d;   // data_out holds a requested byte
    logic        hdr_seen_q, hdr_seen_d;
    logic [7:0]  parity_q, parity_d;
    logic        read_enb_q, read_enb_d;
    logic [7:0]  byte_data_q, byte_data_d;
    logic        byte_vld_q, byte_vld_d;
    logic        pkt_done_q, pkt_done_d;
    logic [5:0]  pkt_len_q, pkt_len_d;
    logic [1:0]  pkt_addr_q, pkt_addr_d;
    logic        parity_err_q, parity_err_d;
    logic        len_err_q, len_err_d;
    logic        trunc_err_q, trunc_err_d;

    logic        in_pkt_s;
    logic        capture_s;
    logic        last_byte_s;
    logic        trunc_s;
    logic        enter_done_s;
    logic        any_err_s;

    // Next-state, read control and datapath
    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        issued_d     = issued_q;
        req_d        = req_q;
        cap_d        = cap_q;
        hdr_seen_d   = hdr_seen_q;
        parity_d     = parity_q;
        pkt_len_d    = pkt_len_q;
        pkt_addr_d   = pkt_addr_q;
        byte_data_d  = byte_data_q;

        in_pkt_s    = (state_q == ST_HDR) || (state_q == ST_BODY);
        capture_s   = in_pkt_s && rd_pend_q;
        // Last byte of a packet is its parity byte; it is checked, not forwarded
        last_byte_s = (state_q == ST_BODY) && capture_s && ((cap_q + 7'd1) == req_q);
        // FIFO ran dry while this packet still needs reads
        trunc_s     = in_pkt_s && !valid_out && (issued_q < req_q);

        case (state_q)
            ST_IDLE: begin
                if (valid_out && sink_en) begin
                    state_d    = ST_WAIT;
                    dly_d      = 5'd0;
                    issued_d   = 7'd0;
                    cap_d      = 7'd0;
                    req_d      = 7'd2;   // header + at least one parity byte
                    hdr_seen_d = 1'b0;
                    parity_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Always at least one WAIT cycle, even for a zero delay
                if ((dly_q + 5'd1) >= RD_C) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_WAIT;
                    dly_d   = dly_q + 5'd1;
                end
            end
            ST_HDR: begin
                if (trunc_s) begin
                    state_d = ST_DONE;
                end else if (capture_s) begin
                    state_d = ST_BODY;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_BODY: begin
                if (last_byte_s) begin
                    state_d = ST_DONE;
                end else if (trunc_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (in_pkt_s && read_enb_q) begin
            issued_d = issued_q + 7'd1;
        end else begin
            issued_d = issued_d;
        end

        // A byte already in flight is still taken on the truncation edge
        if (capture_s) begin
            parity_d = parity_q ^ data_out;
            cap_d    = cap_q + 7'd1;
            if (state_q == ST_HDR) begin
                hdr_seen_d = 1'b1;
                pkt_len_d  = hdr_len(data_out);
                pkt_addr_d = hdr_addr(data_out);
                req_d      = reads_for_hdr(data_out);
            end else begin
                hdr_seen_d = hdr_seen_q;
            end
        end else begin
            parity_d = parity_d;
        end

        rd_pend_d  = read_enb_q && valid_out;
        read_enb_d = ((state_d == ST_HDR) || (state_d == ST_BODY)) && (issued_d < req_d);

        byte_vld_d = (state_q == ST_BODY) && capture_s && !last_byte_s;
        if (byte_vld_d) begin
            byte_data_d = data_out;
        end else begin
            byte_data_d = byte_data_q;
        end

        enter_done_s = (state_d == ST_DONE) && (state_q != ST_DONE);
        pkt_done_d   = enter_done_s;
        trunc_err_d  = enter_done_s && !last_byte_s;
        parity_err_d = last_byte_s && (parity_d != 8'd0);
        len_err_d    = enter_done_s && hdr_seen_d && (pkt_len_d == 6'd0);
        any_err_s    = parity_err_d || len_err_d || trunc_err_d;
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dly_q        <= 5'd0;
            issued_q     <= 7'd0;
            req_q        <= 7'd2;
            cap_q        <= 7'd0;
            rd_pend_q    <= 1'b0;
            hdr_seen_q   <= 1'b0;
            parity_q     <= 8'd0;
            read_enb_q   <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_vld_q   <= 1'b0;
            pkt_done_q   <= 1'b0;
            pkt_len_q    <= 6'd0;
            pkt_addr_q   <= 2'd0;
            parity_err_q <= 1'b0;
            len_err_q    <= 1'b0;
            trunc_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            issued_q     <= issued_d;
            req_q        <= req_d;
            cap_q        <= cap_d;
            rd_pend_q    <= rd_pend_d;
            hdr_seen_q   <= hdr_seen_d;
            parity_q     <= parity_d;
            read_enb_q   <= read_enb_d;
            byte_data_q  <= byte_data_d;
            byte_vld_q   <= byte_vld_d;
            pkt_done_q   <= pkt_done_d;
            pkt_len_q    <= pkt_len_d;
            pkt_addr_q   <= pkt_addr_d;
            parity_err_q <= parity_err_d;
            len_err_q    <= len_err_d;
            trunc_err_q  <= trunc_err_d;
        end
    end

    // Counters step on the DONE-entry edge so they change together with pkt_done
    sat_counter #(.WIDTH(16)) u_pkt_cnt (
        .clock_i (clock),
        .reset_i (reset),
        .inc_i   (enter_done_s),
        .count_o (pkt_count)
    );

    sat_counter #(.WIDTH(8)) u_err_cnt (
        .clock_i (clock),
        .reset_i (reset),
        .inc_i   (enter_done_s && any_err_s),
        .count_o (err_count)
    );

    assign read_enb   = read_enb_q;
    assign byte_data  = byte_data_q;
    assign byte_vld   = byte_vld_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_addr   = pkt_addr_q;
    assign parity_err = parity_err_q;
    assign len_err    = len_err_q;
    assign trunc_err  = trunc_err_q;

endmodule

// File: tb/tb_router_pkt_sink.sv
// Testbench for router_pkt_sink: router FIFO model feeding the sink,
// packet-level reference model and scoreboard, directed and random packets.
module tb_router_pkt_sink;

    localparam int RD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        sink_en;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        read_enb;
    logic [7:0]  byte_data;
    logic        byte_vld;
    logic        pkt_done;
    logic [5:0]  pkt_len;
    logic [1:0]  pkt_addr;
    logic        parity_err;
    logic        len_err;
    logic        trunc_err;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    router_pkt_sink #(.READ_DELAY(RD)) dut (
        .clock      (clock),
        .reset      (reset),
        .sink_en    (sink_en),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .byte_data  (byte_data),
        .byte_vld   (byte_vld),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .pkt_addr   (pkt_addr),
        .parity_err (parity_err),
        .len_err    (len_err),
        .trunc_err  (trunc_err),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Router FIFO model: a read seen at a clock edge pops a byte onto data_out just after it
    logic [7:0] fifo_q[$];
    logic       rd_seen;
    initial begin
        valid_out = 1'b0;
        data_out  = 8'd0;
        forever begin
            @(negedge clock);
            rd_seen = read_enb;
            @(posedge clock);
            #1;
            if (rd_seen && valid_out && (fifo_q.size() > 0)) begin
                data_out = fifo_q.pop_front();
            end
            valid_out = (fifo_q.size() != 0);
        end
    end

    // Reference model: what each packet should produce
    typedef struct {
        logic [5:0] len;
        logic [1:0] addr;
        logic       perr;
        logic       lerr;
        logic       terr;
        int         nbytes;
    } exp_pkt_t;

    exp_pkt_t   exp_q[$];
    logic [7:0] exp_bytes[$];
    int         cur_bytes;
    int         model_pkts;
    int         model_errs;
    logic       cnt_chk_pend;

    // Queue a packet into the FIFO; keep < len leaves it truncated (no parity byte)
    task automatic send_pkt(input int len, input int addr, input bit corrupt, input int keep);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        exp_pkt_t   e;
        hdr = {6'(len), 2'(addr)};
        par = hdr;
        fifo_q.push_back(hdr);
        for (int i = 0; i < keep; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            exp_bytes.push_back(b);
            par = par ^ b;
        end
        if (keep == len) begin
            fifo_q.push_back(corrupt ? (par ^ 8'h01) : par);
        end
        e.len    = 6'(len);
        e.addr   = 2'(addr);
        e.terr   = (keep != len);
        e.perr   = (keep == len) && corrupt;
        e.lerr   = (len == 0);
        e.nbytes = keep;
        exp_q.push_back(e);
    endtask

    // Scoreboard: payload bytes, end-of-packet status, counters one cycle later
    initial begin
        exp_pkt_t e;
        cur_bytes    = 0;
        model_pkts   = 0;
        model_errs   = 0;
        cnt_chk_pend = 1'b0;
        forever begin
            @(negedge clock);
            if (cnt_chk_pend) begin
                check_eq("pkt_count", pkt_count, model_pkts);
                check_eq("err_count", err_count, model_errs);
                cnt_chk_pend = 1'b0;
            end
            if (!reset) begin
                if (byte_vld) begin
                    if (exp_bytes.size() == 0) begin
                        check_eq("extra_byte_vld", byte_vld, 0);
                    end else begin
                        check_eq("byte_data", byte_data, exp_bytes.pop_front());
                    end
                    cur_bytes++;
                end
                if (pkt_done) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_pkt_done", pkt_done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pkt_len", pkt_len, e.len);
                        check_eq("pkt_addr", pkt_addr, e.addr);
                        check_eq("len_err", len_err, e.lerr);
                        check_eq("trunc_err", trunc_err, e.terr);
                        if (!e.terr) begin
                            check_eq("parity_err", parity_err, e.perr);
                        end
                        check_eq("payload_count", cur_bytes, e.nbytes);
                        if (model_pkts < 65535) model_pkts++;
                        if ((e.perr || e.lerr || e.terr) && (model_errs < 255)) model_errs++;
                        cnt_chk_pend = 1'b1;
                    end
                    cur_bytes = 0;
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        check_eq(tag, (exp_q.size() == 0), 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_read_enb"}, read_enb, 0);
        check_eq({tag, "_byte_vld"}, byte_vld, 0);
        check_eq({tag, "_byte_data"}, byte_data, 0);
        check_eq({tag, "_pkt_done"}, pkt_done, 0);
        check_eq({tag, "_errs"}, {parity_err, len_err, trunc_err}, 0);
        check_eq({tag, "_pkt_len"}, pkt_len, 0);
        check_eq({tag, "_pkt_addr"}, pkt_addr, 0);
        check_eq({tag, "_pkt_count"}, pkt_count, 0);
        check_eq({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        int g;
        int hits;
        int len;
        int keep;
        reset   = 1'b1;
        sink_en = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("rst");
        reset   = 1'b0;
        sink_en = 1'b1;

        // Good len-8 packet, header 0x22
        send_pkt(8, 2, 1'b0, 8);
        wait_idle("a_done", 200);
        check_eq("a_pkt_count", pkt_count, 1);

        // Len-5 packet, header 0x16, parity corrupted
        send_pkt(5, 2, 1'b1, 5);
        wait_idle("b_done", 200);
        check_eq("b_err_count", err_count, 1);

        // Zero-length packet: header plus parity only
        send_pkt(0, 1, 1'b0, 0);
        wait_idle("len0_done", 200);

        // Two packets queued back to back
        send_pkt(5, 0, 1'b0, 5);
        send_pkt(5, 3, 1'b0, 5);
        g = 0;
        while (!pkt_done && (g < 200)) begin
            @(negedge clock);
            g++;
        end
        check_eq("c_first_done", pkt_done, 1);
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!read_enb && (g < 50));
        check_eq("c_gap_within_limit", (g <= RD + 2), 1);
        wait_idle("c_done", 300);

        // sink_en held low with data waiting
        sink_en = 1'b0;
        send_pkt(4, 1, 1'b0, 4);
        hits = 0;
        repeat (10) begin
            @(negedge clock);
            if (read_enb) hits++;
        end
        check_eq("d_no_read_while_disabled", hits, 0);
        sink_en = 1'b1;
        g = 0;
        do begin
            @(negedge clock);
            g++;
        end while (!read_enb && (g < 50));
        check_eq("d_start_latency", g, RD + 1);
        wait_idle("d_done", 200);

        // Len-8 packet whose FIFO runs dry after 3 payload bytes
        send_pkt(8, 0, 1'b0, 3);
        wait_idle("e_done", 200);
        check_eq("e_read_enb_low", read_enb, 0);

        // Reset in the middle of a packet
        send_pkt(8, 2, 1'b0, 8);
        g = 0;
        while ((cur_bytes < 4) && (g < 200)) begin
            @(negedge clock);
            g++;
        end
        check_eq("f_reached_4_bytes", (cur_bytes >= 4), 1);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        fifo_q.delete();
        exp_q.delete();
        exp_bytes.delete();
        cur_bytes    = 0;
        model_pkts   = 0;
        model_errs   = 0;
        cnt_chk_pend = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        send_pkt(8, 2, 1'b0, 8);
        wait_idle("f_done", 200);
        check_eq("f_pkt_count", pkt_count, 1);

        // Random packets: lengths, addresses, bad parity, truncation, back-to-back
        for (int it = 0; it < 10; it++) begin
            len  = $urandom_range(0, 12);
            keep = (($urandom % 5) == 0) ? $urandom_range(0, len) : len;
            send_pkt(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)), keep);
            if ((keep == len) && ($urandom_range(0, 1) == 1)) begin
                len = $urandom_range(0, 12);
                send_pkt(len, $urandom_range(0, 3), 1'($urandom_range(0, 1)), len);
            end
            wait_idle("rand_done", 400);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
